// File: rtl/lbist_misr.sv
// lbist_misr: LBIST output response analyser.
//   Compacts N-bit circuit-under-test responses into an N-bit multiple-input
//   signature register, counts accepted responses, and flags done/pass once
//   NUM_PATTERNS responses have been absorbed and compared against GOLDEN.
//
// Optional feature: define LBIST_MISR_XMASK_EN to add the xmask input. Set
//   bits in xmask are cleared from din before compaction, so unknown CUT
//   outputs cannot corrupt the signature.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   1-cycle pulse, begins a session (honoured in IDLE/DONE)
//   en         in   response valid; low cycles are stalls
//   din        in   N-bit CUT response
//   xmask      in   N-bit X mask (only with LBIST_MISR_XMASK_EN)
//   busy       out  high while compacting
//   done       out  high once NUM_PATTERNS responses are absorbed
//   pass       out  done and signature == GOLDEN
//   signature  out  current MISR contents
//   pat_cnt    out  responses accepted in the current session
//
// state   | meaning
// IDLE    | waiting for start, nothing compacted
// COMPACT | absorbing one response per en=1 cycle
// DONE    | session complete, signature and count frozen

module lbist_misr #(
  parameter int             N            = 24,
  parameter logic [N-1:0]   POLY         = 24'hC20001,
  parameter logic [N-1:0]   SEED         = '0,
  parameter int             NUM_PATTERNS = 1024,
  parameter logic [N-1:0]   GOLDEN       = '0,
  parameter int             CW           = $clog2(NUM_PATTERNS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          en,
  input  logic [N-1:0]  din,
`ifdef LBIST_MISR_XMASK_EN
  input  logic [N-1:0]  xmask,
`endif
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [N-1:0]  signature,
  output logic [CW-1:0] pat_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPACT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_PATTERNS - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  sig_q, sig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [N-1:0]  resp;

  always_comb begin
`ifdef LBIST_MISR_XMASK_EN
    resp = din & ~xmask;
`else
    resp = din;
`endif

    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;

    case (state_q)
      // DONE accepts start exactly like IDLE; en is ignored in both.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_COMPACT;
          sig_d   = SEED;
          cnt_d   = '0;
        end
      end
      ST_COMPACT: begin
        // The en mux keeps a garbage din on stall cycles out of the signature.
        if (en) begin
          sig_d = {sig_q[N-2:0], 1'b0} ^ (sig_q[N-1] ? POLY : '0) ^ resp;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next-state values.
    busy_d = (state_d == ST_COMPACT);
    done_d = (state_d == ST_DONE);
    pass_d = (state_d == ST_DONE) && (sig_d == GOLDEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign pat_cnt   = cnt_q;

endmodule

// File: tb/tb_lbist_misr.sv
// tb_lbist_misr: self-checking bench for lbist_misr.
//   Several instances with different session lengths/seeds/goldens share one
//   stimulus stream. A polynomial-arithmetic reference model tracks each one.
//   With LBIST_MISR_XMASK_EN defined an extra instance exercises xmask.

module tb_lbist_misr;

`ifdef LBIST_MISR_XMASK_EN
  localparam int NI = 4;
`else
  localparam int NI = 3;
`endif

  localparam int M_IDLE    = 0;
  localparam int M_COMPACT = 1;
  localparam int M_DONE    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        en = 1'b0;
  logic [23:0] din = '0;
  logic [23:0] xmask = '0;

  always #5 clk = ~clk;

  logic        busy_o [NI];
  logic        done_o [NI];
  logic        pass_o [NI];
  logic [23:0] sig_o  [NI];
  logic [7:0]  cnt_o  [NI];

  logic [1:0]  cnt0;
  logic        cnt1;
  logic [2:0]  cnt2;

  // inst 0: 2 patterns, seed 0, golden 3
  lbist_misr #(.N(24), .POLY(24'hC20001), .SEED(24'h000000), .NUM_PATTERNS(2),
               .GOLDEN(24'h000003)) dut_b (
    .clk(clk), .rst(rst), .start(start), .en(en), .din(din),
`ifdef LBIST_MISR_XMASK_EN
    .xmask(xmask),
`endif
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .signature(sig_o[0]), .pat_cnt(cnt0));

  // inst 1: single pattern, seed with MSB set to exercise feedback
  lbist_misr #(.N(24), .POLY(24'hC20001), .SEED(24'h800000), .NUM_PATTERNS(1),
               .GOLDEN(24'hC20001)) dut_c (
    .clk(clk), .rst(rst), .start(start), .en(en), .din(din),
`ifdef LBIST_MISR_XMASK_EN
    .xmask(xmask),
`endif
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .signature(sig_o[1]), .pat_cnt(cnt1));

  // inst 2: longer session, non-zero seed, used by the random phase
  lbist_misr #(.N(24), .POLY(24'hC20001), .SEED(24'h5A5A5A), .NUM_PATTERNS(5),
               .GOLDEN(24'h000000)) dut_r (
    .clk(clk), .rst(rst), .start(start), .en(en), .din(din),
`ifdef LBIST_MISR_XMASK_EN
    .xmask(xmask),
`endif
    .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
    .signature(sig_o[2]), .pat_cnt(cnt2));

  assign cnt_o[0] = {6'b0, cnt0};
  assign cnt_o[1] = {7'b0, cnt1};
  assign cnt_o[2] = {5'b0, cnt2};

`ifdef LBIST_MISR_XMASK_EN
  logic [2:0] cnt3;
  lbist_misr #(.N(24), .POLY(24'hC20001), .SEED(24'h000000), .NUM_PATTERNS(4),
               .GOLDEN(24'h000000)) dut_x (
    .clk(clk), .rst(rst), .start(start), .en(en), .din(din), .xmask(xmask),
    .busy(busy_o[3]), .done(done_o[3]), .pass(pass_o[3]),
    .signature(sig_o[3]), .pat_cnt(cnt3));
  assign cnt_o[3] = {5'b0, cnt3};
`endif

  // ---------------- reference model ----------------
  int          m_np   [NI];
  logic [23:0] m_seed [NI];
  logic [23:0] m_gold [NI];
  string       m_name [NI];
  int          m_state[NI];
  logic [23:0] m_sig  [NI];
  logic [7:0]  m_cnt  [NI];

  int n_cmp = 0;
  int n_bad = 0;

  // signature' = signature * x + response  (mod P(x)),
  // P(x) = x^24 + x^23 + x^22 + x^17 + 1
  function automatic logic [23:0] misr_next(input logic [23:0] s, input logic [23:0] d);
    logic [24:0] t;
    t = {s, 1'b0} ^ {1'b0, d};
    if (t[24]) t = t ^ 25'h1C20001;
    return t[23:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_state[i] = M_IDLE;
      m_sig[i]   = m_seed[i];
      m_cnt[i]   = '0;
    end
  endtask

  task automatic model_step(input int i, input logic s, input logic e, input logic [23:0] d);
    if (m_state[i] == M_COMPACT) begin
      if (e) begin
        m_sig[i] = misr_next(m_sig[i], d);
        m_cnt[i] = m_cnt[i] + 8'd1;
        if (int'(m_cnt[i]) == m_np[i]) m_state[i] = M_DONE;
      end
    end else if (s) begin
      m_state[i] = M_COMPACT;
      m_sig[i]   = m_seed[i];
      m_cnt[i]   = '0;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int i);
    cmp({m_name[i], " busy"}, 32'(busy_o[i]), 32'(m_state[i] == M_COMPACT));
    cmp({m_name[i], " done"}, 32'(done_o[i]), 32'(m_state[i] == M_DONE));
    cmp({m_name[i], " pass"}, 32'(pass_o[i]),
        32'((m_state[i] == M_DONE) && (m_sig[i] == m_gold[i])));
    cmp({m_name[i], " signature"}, 32'(sig_o[i]), 32'(m_sig[i]));
    cmp({m_name[i], " pat_cnt"}, 32'(cnt_o[i]), 32'(m_cnt[i]));
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) check_inst(i);
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, settle.
  task automatic step(input logic s, input logic e, input logic [23:0] d);
    start = s;
    en    = e;
    din   = d;
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i, s, e, d & ~xmask);
    #1;
  endtask

  // ---------------- directed table for inst 0 ----------------
  typedef struct {
    logic        s;
    logic        e;
    logic [23:0] d;
    logic        busy;
    logic        done;
    logic        pass;
    logic [23:0] sig;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    m_np[0] = 2; m_seed[0] = 24'h000000; m_gold[0] = 24'h000003; m_name[0] = "np2";
    m_np[1] = 1; m_seed[1] = 24'h800000; m_gold[1] = 24'hC20001; m_name[1] = "np1";
    m_np[2] = 5; m_seed[2] = 24'h5A5A5A; m_gold[2] = 24'h000000; m_name[2] = "np5";
`ifdef LBIST_MISR_XMASK_EN
    m_np[3] = 4; m_seed[3] = 24'h000000; m_gold[3] = 24'h000000; m_name[3] = "xm4";
`endif

    //          s  e  din          busy done pass sig          cnt
    tbl[0] = '{1'b1, 1'b1, 24'h000001, 1'b1, 1'b0, 1'b0, 24'h000000, 8'd0}; // en ignored on start
    tbl[1] = '{1'b0, 1'b1, 24'h000001, 1'b1, 1'b0, 1'b0, 24'h000001, 8'd1};
    tbl[2] = '{1'b1, 1'b0, 24'hABCDEF, 1'b1, 1'b0, 1'b0, 24'h000001, 8'd1}; // start ignored, stall
    tbl[3] = '{1'b0, 1'b0, 24'h000001, 1'b1, 1'b0, 1'b0, 24'h000001, 8'd1};
    tbl[4] = '{1'b0, 1'b1, 24'h000001, 1'b0, 1'b1, 1'b1, 24'h000003, 8'd2};
    tbl[5] = '{1'b0, 1'b1, 24'hFFFFFF, 1'b0, 1'b1, 1'b1, 24'h000003, 8'd2}; // frozen in DONE
    tbl[6] = '{1'b1, 1'b1, 24'h000005, 1'b1, 1'b0, 1'b0, 24'h000000, 8'd0}; // restart from DONE
    tbl[7] = '{1'b0, 1'b1, 24'h000002, 1'b1, 1'b0, 1'b0, 24'h000002, 8'd1};
    tbl[8] = '{1'b0, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h000004, 8'd2}; // wrong signature

    // reset state
    model_reset();
    #12;
    check_all();
    cmp("reset np2 signature", 32'(sig_o[0]), 32'h0);
    cmp("reset np2 busy", 32'(busy_o[0]), 32'h0);
    rst = 1'b0;

    // en/din activity in IDLE must not disturb anything
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'(k % 2 == 0), 24'($urandom));
      check_all();
    end
    cmp("idle np2 signature", 32'(sig_o[0]), 32'h0);

    // directed table against inst 0
    for (int k = 0; k < 9; k++) begin
      step(tbl[k].s, tbl[k].e, tbl[k].d);
      cmp($sformatf("tbl%0d busy", k), 32'(busy_o[0]), 32'(tbl[k].busy));
      cmp($sformatf("tbl%0d done", k), 32'(done_o[0]), 32'(tbl[k].done));
      cmp($sformatf("tbl%0d pass", k), 32'(pass_o[0]), 32'(tbl[k].pass));
      cmp($sformatf("tbl%0d signature", k), 32'(sig_o[0]), 32'(tbl[k].sig));
      cmp($sformatf("tbl%0d pat_cnt", k), 32'(cnt_o[0]), 32'(tbl[k].cnt));
      check_all();
    end

    // feedback path on the single-pattern instance
    step(1'b1, 1'b0, 24'h000000);
    cmp("fb start signature", 32'(sig_o[1]), 32'h800000);
    cmp("fb start busy", 32'(busy_o[1]), 32'h1);
    step(1'b0, 1'b1, 24'h000000);
    cmp("fb signature", 32'(sig_o[1]), 32'hC20001);
    cmp("fb done", 32'(done_o[1]), 32'h1);
    cmp("fb pass", 32'(pass_o[1]), 32'h1);
    cmp("fb pat_cnt", 32'(cnt_o[1]), 32'h1);
    step(1'b0, 1'b1, 24'($urandom));
    cmp("fb frozen signature", 32'(sig_o[1]), 32'hC20001);
    check_all();

    // asynchronous reset in the middle of a session
    step(1'b1, 1'b0, 24'h0);
    step(1'b0, 1'b1, 24'($urandom));
    cmp("abort pre busy", 32'(busy_o[0]), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    cmp("abort pat_cnt", 32'(cnt_o[0]), 32'h0);
    cmp("abort busy", 32'(busy_o[0]), 32'h0);
    check_all();
    #2;
    rst = 1'b0;
    step(1'b0, 1'b1, 24'($urandom));
    check_all();

`ifdef LBIST_MISR_XMASK_EN
    step(1'b1, 1'b0, 24'h0);
    xmask = 24'hFFFFFF;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 24'($urandom));
      check_all();
    end
    cmp("xmask signature", 32'(sig_o[3]), 32'h0);
    cmp("xmask done", 32'(done_o[3]), 32'h1);
    cmp("xmask pass", 32'(pass_o[3]), 32'h1);
    xmask = '0;
`endif

    // random traffic against the model on every instance
    for (int k = 0; k < 600; k++) begin
`ifdef LBIST_MISR_XMASK_EN
      xmask = 24'($urandom);
`endif
      step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0), 24'($urandom));
      check_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lbist_misr.md
Name: lbist_misr

Overview:
- Output response analyser downstream of the LBIST pattern generator (LFSR TPG) and the circuit under test.
- Compacts N-bit CUT responses into an N-bit signature using a multiple-input signature register (MISR).
- Counts accepted responses and compares the final signature against a golden value.
- Raises done/pass for the LBIST controller.

Parameters:
- N, 24, signature and response width; must match the TPG width.
- POLY, 24'hC20001, feedback tap mask for x^24+x^23+x^22+x^17+1; bit i is the coefficient of x^i; the x^N term is implicit.
- SEED, 0, signature value loaded on start.
- NUM_PATTERNS, 1024, responses to compact per session; must be >= 1.
- GOLDEN, 24'h000000, expected final signature.
- CW, $clog2(NUM_PATTERNS+1), pattern counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle pulse; begins a compaction session.
- en  in  1  response valid; same stall semantics as the TPG en.
- din  in  N  CUT response word.
- busy  out  1  high in COMPACT.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when signature == GOLDEN.
- signature  out  N  current MISR contents.
- pat_cnt  out  CW  responses accepted in the current session.

Behaviour:
- Reset:
  - rst=1 asynchronously forces state=IDLE, signature=SEED, pat_cnt=0.
  - busy=0, done=0, pass=0.
  - Reset mid-session aborts the session; no partial result is kept.
- States: IDLE, COMPACT, DONE. All registers are clocked on the rising edge of clk.
- IDLE:
  - start=1: load signature=SEED and pat_cnt=0, go to COMPACT.
  - en is ignored in IDLE, including in the start cycle.
- COMPACT, when en=1, one response is accepted per cycle:
  - fb = signature[N-1].
  - signature <= {signature[N-2:0],1'b0} ^ (fb ? POLY : 0) ^ din.
  - pat_cnt <= pat_cnt+1.
- COMPACT, when en=0: signature and pat_cnt hold, with no gaps counted.
- COMPACT to DONE: on the edge that accepts response number NUM_PATTERNS (pat_cnt == NUM_PATTERNS-1 and en=1).
- Latency:
  - done rises in the cycle after the last accepted response.
  - signature is final in that same cycle.
- start during COMPACT is ignored; it does not restart the session.
- en in DONE is ignored; signature and pat_cnt are frozen (pat_cnt == NUM_PATTERNS).
- DONE holds until reset or start. start in DONE behaves exactly as start in IDLE: load SEED, clear counter, go to COMPACT, deassert done/pass in the next cycle.
- pass = done & (signature == GOLDEN). It is 0 outside DONE.
- busy = (state == COMPACT). done = (state == DONE). busy and done are never both high.
- NUM_PATTERNS=1: one accepted response moves the block to DONE.
- X on din while en=0 must not affect signature.

Optional Feature:
- Macro: LBIST_MISR_XMASK_EN.
- With the macro defined:
  - Adds input port xmask [N-1:0], placed after din.
  - Compaction uses (din & ~xmask), so masked bits (unknown CUT outputs) never corrupt the signature.
  - xmask is sampled only on accepted cycles.
- Without the macro: no xmask port; din is used unmasked. Behaviour is otherwise identical.

Test Plan:
- Reset/idle: assert rst with start=0 -> busy=0, done=0, pass=0, signature=0, pat_cnt=0. Toggling en/din in IDLE leaves signature=0.
- Basic compaction, NUM_PATTERNS=2, SEED=0:
  - start, then din=24'h000001 en=1 for 2 cycles -> signature 24'h000001 then 24'h000003.
  - done=1 one cycle after the second accept; pass=1 iff GOLDEN=24'h000003.
- Feedback path, NUM_PATTERNS=1, SEED=24'h800000: start, din=0 en=1 -> signature=24'hC20001, done=1.
- Stall: en pattern 1,0,0,1 with din=1 each cycle, NUM_PATTERNS=2 -> pat_cnt 1,1,1,2, final signature=24'h000003, and done only after the second en=1.
- Restart/abort:
  - start during COMPACT -> ignored, counter continues.
  - start in DONE -> done=0 next cycle and signature=SEED.
  - rst pulse mid-COMPACT -> IDLE, pat_cnt=0 immediately (asynchronous).
- Xmask (macro defined): xmask=24'hFFFFFF with random din for NUM_PATTERNS=4, SEED=0 -> signature stays 0, pass=1 for GOLDEN=0.
